// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
//
// Bundles the three block-transfer channels around the memory controller:
//   icache_* : icache miss port (read-only requests, refill responses)
//   dcache_* : dcache miss / write-through port (read or write requests)
//   mem_*    : main-memory port (one outstanding transaction)
//
// Modports:
//   slave  : the controller's view (takes cache requests, drives memory requests)
//   master : the surrounding caches and main memory (drive cache requests,
//            accept memory requests, return memory responses)
//
// Request type encoding on *_req_type: READ = 0, WRITE = 1.
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int BLOCK_DATA_WIDTH = 64
) ();

  // icache channel
  logic                        icache_req_valid;
  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr;
  logic                        icache_req_ready;
  logic                        icache_resp_valid;
  logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data;

  // dcache channel
  logic                        dcache_req_valid;
  logic                        dcache_req_type;
  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr;
  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data;
  logic                        dcache_req_ready;
  logic                        dcache_resp_valid;
  logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data;

  // main-memory channel
  logic                        mem_req_valid;
  logic                        mem_req_type;
  logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr;
  logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data;
  logic                        mem_req_ready;
  logic                        mem_resp_valid;
  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data;

  modport slave (
    input  icache_req_valid, icache_req_block_addr,
    output icache_req_ready, icache_resp_valid, icache_resp_block_data,
    input  dcache_req_valid, dcache_req_type, dcache_req_block_addr,
           dcache_req_block_data,
    output dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
    output mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_block_data
  );

  modport master (
    output icache_req_valid, icache_req_block_addr,
    input  icache_req_ready, icache_resp_valid, icache_resp_block_data,
    output dcache_req_valid, dcache_req_type, dcache_req_block_addr,
           dcache_req_block_data,
    input  dcache_req_ready, dcache_resp_valid, dcache_resp_block_data,
    input  mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
    output mem_req_ready, mem_resp_valid, mem_resp_block_data
  );

endinterface : mem_ctrl_if

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
//
// Memory controller between the icache/dcache miss ports and main memory.
// Arbitrates block requests (icache has priority), issues exactly one
// transaction at a time to main memory and routes the single-cycle response
// pulse back to the cache that owns the transaction. A one-entry holding
// buffer captures an icache request that arrives while the controller is
// busy, so the icache request path is always ready.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset (drops any transaction silently)
//   bus  : mem_ctrl_if.slave -- icache, dcache and main-memory channels
//   perf_icache_reqs, perf_dcache_reqs, perf_busy_cycles (32 bit each):
//          present only when MEM_CTRL_PERF_CNT_EN is defined; grant counts
//          per cache and count of non-idle cycles, wrapping, cleared by rst.
//
// Configuration macro: MEM_CTRL_PERF_CNT_EN (undefined by default).
//
// Timing: request cycle (IDLE grant) -> ISSUE (mem_req_valid) -> WAIT until
// mem_resp_valid; the response cycle returns to IDLE, where the next grant
// can be made, giving one idle bubble per transaction.
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int BLOCK_ADDR_WIDTH = 29,
  parameter int BLOCK_DATA_WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_ctrl_if.slave    bus
`ifdef MEM_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]  perf_icache_reqs,
  output logic [31:0]  perf_dcache_reqs,
  output logic [31:0]  perf_busy_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_type_t;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } owner_t;

  // Transaction register: everything main memory sees comes from here, so the
  // request fields stay stable for as long as mem_req_ready is held low.
  typedef struct packed {
    owner_t                      owner;
    req_type_t                   req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] addr;
    logic [BLOCK_DATA_WIDTH-1:0] data;
  } txn_t;

  state_t                      state;
  txn_t                        txn;
  logic                        mem_req_valid_q;

  logic                        ibuf_valid;
  logic [BLOCK_ADDR_WIDTH-1:0] ibuf_addr;

  logic                        grant_icache;
  logic                        grant_dcache;
  txn_t                        grant_txn;

  logic                        resp_fire;

  // ---------------------------------------------------------------------------
  // IDLE grant. A buffered icache request goes first, then a live icache
  // request (bypassing the buffer for zero added latency), then the dcache.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    grant_icache       = 1'b0;
    grant_dcache       = 1'b0;
    grant_txn.owner    = OWN_DCACHE;
    grant_txn.req_type = req_type_t'(bus.dcache_req_type);
    grant_txn.addr     = bus.dcache_req_block_addr;
    grant_txn.data     = bus.dcache_req_block_data;

    if (state == IDLE) begin
      if (ibuf_valid) begin
        grant_icache       = 1'b1;
        grant_txn.owner    = OWN_ICACHE;
        grant_txn.req_type = REQ_READ;
        grant_txn.addr     = ibuf_addr;
        grant_txn.data     = '0;
      end else if (bus.icache_req_valid) begin
        grant_icache       = 1'b1;
        grant_txn.owner    = OWN_ICACHE;
        grant_txn.req_type = REQ_READ;
        grant_txn.addr     = bus.icache_req_block_addr;
        grant_txn.data     = '0;
      end else if (bus.dcache_req_valid) begin
        grant_dcache       = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state           <= IDLE;
      txn             <= '0;
      mem_req_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_icache || grant_dcache) begin
            txn             <= grant_txn;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state <= IDLE;
          end
        end
        default: begin
          state           <= IDLE;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // icache holding buffer. A request that is not granted directly (controller
  // busy) is parked here; a grant from the buffer in IDLE empties it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ibuf_valid <= 1'b0;
      ibuf_addr  <= '0;
    end else begin
      if (state == IDLE && ibuf_valid) begin
        ibuf_valid <= 1'b0;
      end
      if (bus.icache_req_valid && !(state == IDLE && !ibuf_valid)) begin
        ibuf_valid <= 1'b1;
        ibuf_addr  <= bus.icache_req_block_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign bus.icache_req_ready = 1'b1;

  // The dcache is only accepted when nothing from the icache competes for the
  // IDLE grant; otherwise it must hold its request.
  assign bus.dcache_req_ready = (state == IDLE) && !ibuf_valid &&
                                !bus.icache_req_valid;

  assign bus.mem_req_valid      = mem_req_valid_q;
  assign bus.mem_req_type       = txn.req_type;
  assign bus.mem_req_block_addr = txn.addr;
  assign bus.mem_req_block_data = txn.data;

  // Responses pass straight through in the memory response cycle.
  assign resp_fire = bus.mem_resp_valid && (state == WAIT);

  assign bus.icache_resp_valid = resp_fire && (txn.owner == OWN_ICACHE);
  assign bus.dcache_resp_valid = resp_fire && (txn.owner == OWN_DCACHE);

  assign bus.icache_resp_block_data = bus.icache_resp_valid ?
                                      bus.mem_resp_block_data : '0;
  // Write acks carry no data.
  assign bus.dcache_resp_block_data =
      (bus.dcache_resp_valid && txn.req_type == REQ_READ) ?
      bus.mem_resp_block_data : '0;

  // ---------------------------------------------------------------------------
  // Optional performance counters.
  // ---------------------------------------------------------------------------
`ifdef MEM_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_icache_reqs <= '0;
      perf_dcache_reqs <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (grant_icache) perf_icache_reqs <= perf_icache_reqs + 32'd1;
      if (grant_dcache) perf_dcache_reqs <= perf_dcache_reqs + 32'd1;
      if (state != IDLE) perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`else
  // Counters are absent in this build.
`endif

  // ---------------------------------------------------------------------------
  // Protocol checks.
  // ---------------------------------------------------------------------------
  // The icache never issues a new request while one of its own is pending.
  a_icache_single_outstanding : assert property (
    @(posedge clk) disable iff (rst)
    bus.icache_req_valid |->
      !ibuf_valid && !(state != IDLE && txn.owner == OWN_ICACHE)
  ) else $error("mem_ctrl: icache request while icache request pending");

  // Main memory only responds to an accepted request, at least one cycle later.
  a_mem_resp_in_wait : assert property (
    @(posedge clk) disable iff (rst)
    bus.mem_resp_valid |-> (state == WAIT)
  ) else $error("mem_ctrl: mem_resp_valid outside WAIT");

endmodule : mem_ctrl

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
//
// Directed testbench for mem_ctrl. The bench plays icache, dcache and main
// memory through a mem_ctrl_if instance. Inputs change 1 time unit after the
// rising edge; outputs are compared 2 units after the edge.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 29;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fails  = 0;

  mem_ctrl_if #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) bus ();

`ifdef MEM_CTRL_PERF_CNT_EN
  logic [31:0] perf_icache_reqs;
  logic [31:0] perf_dcache_reqs;
  logic [31:0] perf_busy_cycles;
`endif

  mem_ctrl #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave)
`ifdef MEM_CTRL_PERF_CNT_EN
    ,
    .perf_icache_reqs (perf_icache_reqs),
    .perf_dcache_reqs (perf_dcache_reqs),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

`ifdef MEM_CTRL_PERF_CNT_EN
  // One complete transaction: grant in IDLE, `stall` extra ISSUE cycles,
  // response in the `wait_n`-th WAIT cycle.
  task automatic do_txn(input bit is_icache, input logic [AW-1:0] addr,
                        input int stall, input int wait_n);
    if (is_icache) begin
      bus.icache_req_valid      = 1'b1;
      bus.icache_req_block_addr = addr;
    end else begin
      bus.dcache_req_valid      = 1'b1;
      bus.dcache_req_type       = 1'b0;
      bus.dcache_req_block_addr = addr;
    end
    cyc();
    bus.icache_req_valid = 1'b0;
    bus.dcache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b0;
    repeat (stall) cyc();
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    repeat (wait_n - 1) cyc();
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'h0123_4567_89AB_CDEF;
    settle();
    if (is_icache) check("perf_txn_icache_pulse", bus.icache_resp_valid, 1);
    else           check("perf_txn_dcache_pulse", bus.dcache_resp_valid, 1);
    cyc();
    bus.mem_resp_valid = 1'b0;
  endtask
`endif

  initial begin
    rst                       = 1'b1;
    bus.icache_req_valid      = 1'b0;
    bus.icache_req_block_addr = '0;
    bus.dcache_req_valid      = 1'b0;
    bus.dcache_req_type       = 1'b0;
    bus.dcache_req_block_addr = '0;
    bus.dcache_req_block_data = '0;
    bus.mem_req_ready         = 1'b0;
    bus.mem_resp_valid        = 1'b0;
    bus.mem_resp_block_data   = '0;

    // ---------------- reset state ----------------
    cyc();
    cyc();
    settle();
    check("rst_mem_req_valid",    bus.mem_req_valid, 0);
    check("rst_mem_req_addr",     bus.mem_req_block_addr, 0);
    check("rst_mem_req_data",     bus.mem_req_block_data, 0);
    check("rst_icache_req_ready", bus.icache_req_ready, 1);
    check("rst_dcache_req_ready", bus.dcache_req_ready, 1);
    check("rst_icache_resp",      bus.icache_resp_valid, 0);
    check("rst_dcache_resp",      bus.dcache_resp_valid, 0);
`ifdef MEM_CTRL_PERF_CNT_EN
    check("rst_perf_i",    perf_icache_reqs, 0);
    check("rst_perf_d",    perf_dcache_reqs, 0);
    check("rst_perf_busy", perf_busy_cycles, 0);
`endif
    cyc();
    rst = 1'b0;

    // ---------------- T1: icache read 0x100 ----------------
    // cycle 1: request (IDLE grant)
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 29'h100;
    settle();
    check("t1_dcache_ready_blocked", bus.dcache_req_ready, 0);
    cyc();
    // cycle 2: ISSUE
    bus.icache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    settle();
    check("t1_mem_req_valid", bus.mem_req_valid, 1);
    check("t1_mem_req_type",  bus.mem_req_type, 0);
    check("t1_mem_req_addr",  bus.mem_req_block_addr, 64'h100);
    cyc();
    // cycle 3: WAIT, no response yet
    bus.mem_req_ready = 1'b0;
    settle();
    check("t1_mem_req_dropped", bus.mem_req_valid, 0);
    check("t1_no_early_resp",   bus.icache_resp_valid, 0);
    cyc();
    // cycle 4: response
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'hDEAD_BEEF_CAFE_F00D;
    settle();
    check("t1_icache_resp_valid", bus.icache_resp_valid, 1);
    check("t1_icache_resp_data",  bus.icache_resp_block_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1_dcache_resp_quiet", bus.dcache_resp_valid, 0);
    cyc();
    // cycle 5: IDLE, pulse gone
    bus.mem_resp_valid = 1'b0;
    settle();
    check("t1_icache_resp_single", bus.icache_resp_valid, 0);

    // ---------------- T2: icache and dcache write together ----------------
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 29'h40;
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_type       = 1'b1;
    bus.dcache_req_block_addr = 29'h200;
    bus.dcache_req_block_data = 64'h11;
    settle();
    check("t2_dcache_ready_tie", bus.dcache_req_ready, 0);
    cyc();
    // ISSUE for icache
    bus.icache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    settle();
    check("t2_dcache_ready_issue", bus.dcache_req_ready, 0);
    check("t2_icache_first_addr",  bus.mem_req_block_addr, 64'h40);
    check("t2_icache_first_type",  bus.mem_req_type, 0);
    cyc();
    // WAIT: icache response
    bus.mem_req_ready       = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'h55;
    settle();
    check("t2_dcache_ready_wait", bus.dcache_req_ready, 0);
    check("t2_icache_resp",       bus.icache_resp_valid, 1);
    check("t2_dcache_resp_quiet", bus.dcache_resp_valid, 0);
    cyc();
    // IDLE: dcache granted
    bus.mem_resp_valid = 1'b0;
    settle();
    check("t2_dcache_ready_idle", bus.dcache_req_ready, 1);
    cyc();
    // ISSUE for dcache write
    bus.dcache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    settle();
    check("t2_dw_valid", bus.mem_req_valid, 1);
    check("t2_dw_type",  bus.mem_req_type, 1);
    check("t2_dw_addr",  bus.mem_req_block_addr, 64'h200);
    check("t2_dw_data",  bus.mem_req_block_data, 64'h11);
    cyc();
    // WAIT: write ack with garbage on the data bus
    bus.mem_req_ready       = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'hFFFF_0000_FFFF_0000;
    settle();
    check("t2_dw_resp_valid",     bus.dcache_resp_valid, 1);
    check("t2_dw_resp_data_zero", bus.dcache_resp_block_data, 0);
    check("t2_dw_icache_quiet",   bus.icache_resp_valid, 0);
    cyc();
    bus.mem_resp_valid = 1'b0;

    // ---------------- T3: icache arrives while dcache read waits ----------------
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_type       = 1'b0;
    bus.dcache_req_block_addr = 29'h300;
    settle();
    check("t3_dcache_ready", bus.dcache_req_ready, 1);
    cyc();
    // ISSUE
    bus.dcache_req_valid = 1'b0;
    bus.mem_req_ready    = 1'b1;
    settle();
    check("t3_dr_addr", bus.mem_req_block_addr, 64'h300);
    cyc();
    // WAIT: icache request gets buffered, dcache presents its next request
    bus.mem_req_ready         = 1'b0;
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 29'h80;
    bus.dcache_req_valid      = 1'b1;
    bus.dcache_req_type       = 1'b0;
    bus.dcache_req_block_addr = 29'h310;
    settle();
    check("t3_icache_ready_busy", bus.icache_req_ready, 1);
    cyc();
    // WAIT: dcache response
    bus.icache_req_valid    = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'hAAAA_BBBB_CCCC_DDDD;
    settle();
    check("t3_dr_resp_valid",   bus.dcache_resp_valid, 1);
    check("t3_dr_resp_data",    bus.dcache_resp_block_data, 64'hAAAA_BBBB_CCCC_DDDD);
    check("t3_dr_icache_quiet", bus.icache_resp_valid, 0);
    cyc();
    // IDLE: buffered icache wins over the waiting dcache
    bus.mem_resp_valid = 1'b0;
    settle();
    check("t3_dcache_held_off", bus.dcache_req_ready, 0);
    cyc();
    // ISSUE for buffered icache
    bus.mem_req_ready = 1'b1;
    settle();
    check("t3_ibuf_addr", bus.mem_req_block_addr, 64'h80);
    check("t3_ibuf_type", bus.mem_req_type, 0);
    cyc();
    bus.mem_req_ready       = 1'b0;
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'h8080;
    settle();
    check("t3_ibuf_resp", bus.icache_resp_valid, 1);
    cyc();
    // IDLE: dcache 0x310 finally granted
    bus.mem_resp_valid = 1'b0;
    settle();
    check("t3_dcache_ready_late", bus.dcache_req_ready, 1);
    cyc();
    bus.dcache_req_valid = 1'b0;

    // ---------------- T4: mem_req_ready low for 5 ISSUE cycles ----------------
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_stall_valid", bus.mem_req_valid, 1);
      check("t4_stall_addr",  bus.mem_req_block_addr, 64'h310);
      check("t4_stall_type",  bus.mem_req_type, 0);
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    settle();
    check("t4_accept_addr", bus.mem_req_block_addr, 64'h310);
    cyc();
    bus.mem_req_ready = 1'b0;
    settle();
    check("t4_single_issue", bus.mem_req_valid, 0);

    // ---------------- T5: reset during WAIT ----------------
    // still in WAIT for dcache 0x310; buffer an icache request first
    bus.icache_req_valid      = 1'b1;
    bus.icache_req_block_addr = 29'h90;
    cyc();
    bus.icache_req_valid = 1'b0;
    rst                  = 1'b1;
    cyc();
    // second reset cycle: a late memory response must not reach either cache
    bus.mem_resp_valid      = 1'b1;
    bus.mem_resp_block_data = 64'h1234;
    settle();
    check("t5_no_icache_pulse", bus.icache_resp_valid, 0);
    check("t5_no_dcache_pulse", bus.dcache_resp_valid, 0);
    check("t5_mem_req_valid",   bus.mem_req_valid, 0);
    check("t5_dcache_ready",    bus.dcache_req_ready, 1);
    cyc();
    rst                = 1'b0;
    bus.mem_resp_valid = 1'b0;
    settle();
    check("t5_idle_ready",  bus.dcache_req_ready, 1);
    check("t5_idle_no_req", bus.mem_req_valid, 0);
    cyc();
    settle();
    check("t5_ibuf_dropped", bus.mem_req_valid, 0);
    cyc();

`ifdef MEM_CTRL_PERF_CNT_EN
    // ---------------- T6: performance counters ----------------
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("t6_perf_clear", perf_busy_cycles, 0);
    // busy cycles per txn = (stall + 1) + wait_n: 2 + 4 + 2 + 4 + 4 = 16
    do_txn(1'b1, 29'h500, 0, 1);
    do_txn(1'b0, 29'h600, 1, 2);
    do_txn(1'b1, 29'h510, 0, 1);
    do_txn(1'b0, 29'h610, 2, 1);
    do_txn(1'b1, 29'h520, 0, 3);
    settle();
    check("t6_perf_icache", perf_icache_reqs, 3);
    check("t6_perf_dcache", perf_dcache_reqs, 2);
    check("t6_perf_busy",   perf_busy_cycles, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule : tb_mem_ctrl

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly downstream of the icache and dcache miss/write-through ports and upstream of main memory.
- Arbitrates block requests from the two caches, with icache priority, and issues one transaction at a time to main memory.
- Returns each response as a single-cycle pulse to the cache that owns the transaction.
- Contains a one-entry icache holding buffer so the icache request path is always ready.

Parameters:
BLOCK_ADDR_WIDTH, 29, width of a main-memory block address (ADDR_WIDTH minus block offset bits)
BLOCK_DATA_WIDTH, 64, width of one cache block in bits

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
icache_req_valid  in  1  icache request (always read)
icache_req_block_addr  in  BLOCK_ADDR_WIDTH  icache block address
icache_req_ready  out  1  constant 1; accepted into holding buffer
icache_resp_valid  out  1  one-cycle response pulse to icache
icache_resp_block_data  out  BLOCK_DATA_WIDTH  refill data
dcache_req_valid  in  1  dcache request
dcache_req_type  in  1  req_type_t: READ=0, WRITE=1
dcache_req_block_addr  in  BLOCK_ADDR_WIDTH  dcache block address
dcache_req_block_data  in  BLOCK_DATA_WIDTH  write-through data
dcache_req_ready  out  1  dcache request accepted this cycle when valid&ready
dcache_resp_valid  out  1  one-cycle response pulse to dcache (reads and writes)
dcache_resp_block_data  out  BLOCK_DATA_WIDTH  refill data; 0 for write acks
mem_req_valid  out  1  request to main memory
mem_req_type  out  1  READ/WRITE
mem_req_block_addr  out  BLOCK_ADDR_WIDTH  block address
mem_req_block_data  out  BLOCK_DATA_WIDTH  write data
mem_req_ready  in  1  main memory accepts when valid&ready
mem_resp_valid  in  1  read data or write ack, one cycle
mem_resp_block_data  in  BLOCK_DATA_WIDTH  read data

Behaviour:
- Reset (rst high at posedge): state=IDLE; ibuf_valid=0; all out valids=0; data outputs=0; icache_req_ready stays 1. Reset mid-transaction drops it silently, with no response pulse; main memory is reset in the same cycle.
- Holding buffer: icache_req_valid loads ibuf (addr, ibuf_valid=1) at the posedge. The icache never issues while a response is pending; a second valid while ibuf_valid=1 or an icache transaction is in flight is a protocol error (simulation assertion).
- FSM states IDLE, ISSUE, WAIT.
- IDLE grant, evaluated combinationally:
  - If ibuf_valid, grant icache and clear ibuf.
  - Else if icache_req_valid, grant icache directly, bypassing ibuf (zero added latency).
  - Else if dcache_req_valid, grant dcache.
  - dcache_req_ready = (state==IDLE) & ~ibuf_valid & ~icache_req_valid.
  - A grant latches owner, type (icache forces READ), addr and data into the txn register; next state is ISSUE.
- ISSUE: mem_req_valid=1 driven from the txn register.
  - mem_req_valid&mem_req_ready moves to WAIT.
  - Otherwise hold, with fields stable.
- WAIT: on mem_resp_valid, pulse the owner's resp_valid for exactly the same cycle, combinationally from mem_resp_valid & state==WAIT & owner. Next state is IDLE.
  - A write ack drives dcache_resp_block_data=0.
  - A response in the same cycle as the request handshake is illegal; main memory responds ≥1 cycle after acceptance.
- Minimum cache-to-response latency is 3 cycles: request cycle, ISSUE cycle, earliest response.
- Back-to-back: the response cycle goes to IDLE; the next grant occurs in that IDLE cycle, so one idle bubble per transaction.
- Simultaneous events:
  - icache and dcache valid together in IDLE: icache wins; dcache sees ready=0 and must hold its request.
  - icache valid arriving during ISSUE/WAIT: buffered; served before any dcache request.
- The non-owner resp_valid is never asserted. mem_resp_valid outside WAIT is ignored (assertion).

Optional Feature:
MEM_CTRL_PERF_CNT_EN
- Defined: adds outputs perf_icache_reqs[31:0], perf_dcache_reqs[31:0] and perf_busy_cycles[31:0].
  - perf_icache_reqs and perf_dcache_reqs increment on each grant.
  - perf_busy_cycles increments every cycle state!=IDLE.
  - All counters wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Icache read 0x100, memory ready=1, responds 2 cycles after accept with 0xDEADBEEF_CAFEF00D -> icache_resp_valid one pulse at cycle 4 with that data; dcache_resp_valid stays 0.
- Icache and dcache valid in the same cycle (dcache WRITE 0x200 data 0x11) -> icache served first; dcache_req_ready=0 until the next IDLE; dcache write issued next; dcache_resp_valid pulse with data 0.
- Dcache read in WAIT, then icache valid arrives -> ibuf captures it; after the dcache response, icache is granted in the next IDLE cycle even though dcache_req_valid=1.
- mem_req_ready held 0 for 5 cycles during ISSUE -> mem_req_* fields stable all 5 cycles; one transaction issued.
- rst asserted during WAIT -> next cycle all valids 0, ibuf_valid 0, state IDLE; a later mem_resp_valid produces no cache pulse.
- With MEM_CTRL_PERF_CNT_EN: 3 icache and 2 dcache transactions -> counters read 3 and 2; busy count equals the summed ISSUE+WAIT cycles.
